mem_store_ctrl: RTL and testbench

Write-sequencing stage that feeds the board's 4 x 8-bit switch-addressed memory. It synchronises and debounces the raw centre button and turns each clean press into exactly one write strobe. On that strobe it captures the switch data into the selected entry. It also provides a registered read-back port for the LEDs, so the demux/latch path is replaced by a clocked, glitch-free store.

---
 rtl/mem_store_pkg.sv | 14 +
 rtl/mem_store_ctrl_btn_sync.sv | 22 ++
 rtl/mem_store_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_store_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_pkg.sv
// Shared types and default sizing for the switch-addressed write store.
package mem_store_pkg;
    localparam int DEF_DATA_W          = 8;
    localparam int DEF_DEPTH           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        WRITE     = 3'd2,
        WAIT_REL  = 3'd3,
        DEB_REL   = 3'd4
    } state_t;
endpackage

// File: rtl/mem_store_ctrl_btn_sync.sv
// Two-flop synchroniser for the raw write button; both flops clear on reset.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;
endmodule

// File: rtl/mem_store_ctrl.sv
// Debounced single-write sequencer feeding a small clocked store with a registered read port.
// Optional write counter output wr_count is built when MEM_STORE_WRCOUNT_EN is defined.
module mem_store_ctrl
    import mem_store_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_btn,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [DEPTH-1:0]         valid,
    output logic                     wr_pulse,
    output logic                     busy,
`ifdef MEM_STORE_WRCOUNT_EN
    output logic [7:0]               wr_count,
`endif
    output logic [2:0]               dbg_state
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic                 w_btn_s;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_wr_pulse;
    logic                 r_busy;
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [DATA_W-1:0]    r_rd_data;
`ifdef MEM_STORE_WRCOUNT_EN
    logic [7:0]           r_wr_count;
`endif

    btn_sync u_btn_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (wr_btn),
        .o_sync  (w_btn_s)
    );

    // wr_pulse and busy are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wr_pulse <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_wr_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_s) begin
                        r_state <= DEB_PRESS;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!w_btn_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt < CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state    <= WRITE;
                        r_wr_pulse <= 1'b1;
                    end
                end
                WRITE: begin
                    r_state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!w_btn_s) begin
                        r_state <= DEB_REL;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                DEB_REL: begin
                    if (w_btn_s) begin
                        r_state <= WAIT_REL;
                    end else if (r_cnt < CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write commits on the edge that closes the WRITE cycle; the read samples the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid   <= '0;
            r_rd_data <= '0;
        end else begin
            if (r_state == WRITE) begin
                r_mem[wr_addr]   <= wr_data;
                r_valid[wr_addr] <= 1'b1;
            end
            r_rd_data <= r_mem[rd_addr];
        end
    end

`ifdef MEM_STORE_WRCOUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (r_state == WRITE) begin
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    assign wr_count = r_wr_count;
`endif

    assign rd_data   = r_rd_data;
    assign valid     = r_valid;
    assign wr_pulse  = r_wr_pulse;
    assign busy      = r_busy;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed bench for mem_store_ctrl with a 4-cycle debounce window.
module tb_mem_store_ctrl;
    import mem_store_pkg::*;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_btn = 1'b0;
    logic [7:0] wr_data = '0;
    logic [1:0] wr_addr = '0;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [3:0] valid;
    logic       wr_pulse;
    logic       busy;
    logic [2:0] dbg_state;
`ifdef MEM_STORE_WRCOUNT_EN
    logic [7:0] wr_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;
    logic [7:0] exp_q[$];

    mem_store_ctrl #(
        .DATA_W          (8),
        .DEPTH           (4),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_btn    (wr_btn),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .valid     (valid),
        .wr_pulse  (wr_pulse),
        .busy      (busy),
`ifdef MEM_STORE_WRCOUNT_EN
        .wr_count  (wr_count),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each; counts observed write pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (wr_pulse) n_pulse++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        step(1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic press(input logic [1:0] addr, input logic [7:0] data);
        wr_addr = addr;
        wr_data = data;
        wr_btn  = 1'b1;
        step(12);
        wr_btn  = 1'b0;
        step(12);
    endtask

    initial begin
        int p0;
        int first_k;
        int npk;
        logic [7:0] rd_k8;
        logic [7:0] rd_k9;
        logic [7:0] bounce_pat;

        // 1. Reset
        rst = 1'b1;
        step(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulse", 32'(wr_pulse), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        for (int a = 0; a < 4; a++) read_chk("rst_rd", 2'(a), 8'h00);

        // 2. Clean press; button rises just after an edge so the next edge is e0 (k=1)
        wr_addr = 2'd2;
        wr_data = 8'hA5;
        rd_addr = 2'd2;
        wr_btn  = 1'b1;
        first_k = 0;
        npk = 0;
        rd_k8 = '1;
        rd_k9 = '1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (wr_pulse) begin
                npk++;
                if (first_k == 0) first_k = k;
            end
            if (k == DC + 4) rd_k8 = rd_data;
            if (k == DC + 5) rd_k9 = rd_data;
        end
        check("press_npulse", 32'(npk), 32'd1);
        check("press_latency", 32'(first_k), 32'(DC + 3));
        check("rd_same_edge_old", 32'(rd_k8), 32'h00);
        check("rd_next_edge_new", 32'(rd_k9), 32'hA5);
        check("press_busy_held", 32'(busy), 32'd1);
        wr_btn = 1'b0;
        step(12);
        check("press_valid", 32'(valid), 32'b0100);
        check("press_busy_rel", 32'(busy), 32'd0);
        read_chk("press_rd2", 2'd2, 8'hA5);

        // 3. Bounce reject
        p0 = n_pulse;
        wr_addr = 2'd0;
        wr_data = 8'hFF;
        bounce_pat = 8'b1101_0110;
        for (int i = 7; i >= 0; i--) begin
            wr_btn = bounce_pat[i];
            step(1);
        end
        wr_btn = 1'b0;
        step(12);
        check("bounce_npulse", 32'(n_pulse - p0), 32'd0);
        check("bounce_valid", 32'(valid), 32'b0100);
        check("bounce_busy", 32'(busy), 32'd0);
        read_chk("bounce_rd0", 2'd0, 8'h00);
        read_chk("bounce_rd2", 2'd2, 8'hA5);

        // 4. Long hold plus release bounce
        p0 = n_pulse;
        wr_addr = 2'd3;
        wr_data = 8'h5A;
        wr_btn  = 1'b1;
        step(200);
        check("hold_busy", 32'(busy), 32'd1);
        bounce_pat = 8'b0010_0100;
        for (int i = 7; i >= 0; i--) begin
            wr_btn = bounce_pat[i];
            step(1);
        end
        wr_btn = 1'b0;
        step(20);
        check("hold_npulse", 32'(n_pulse - p0), 32'd1);
        check("hold_valid", 32'(valid), 32'b1100);
        check("hold_busy_rel", 32'(busy), 32'd0);
        read_chk("hold_rd3", 2'd3, 8'h5A);

        // 5. Fill and overwrite from a fresh reset
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("fill_valid_rst", 32'(valid), 32'd0);
        p0 = n_pulse;
        press(2'd0, 8'h11);
        press(2'd1, 8'h22);
        press(2'd2, 8'h33);
        press(2'd3, 8'h44);
        press(2'd1, 8'h99);
        check("fill_npulse", 32'(n_pulse - p0), 32'd5);
        check("fill_valid", 32'(valid), 32'b1111);
`ifdef MEM_STORE_WRCOUNT_EN
        check("fill_wr_count", 32'(wr_count), 32'd5);
`endif
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        for (int a = 0; a < 4; a++) read_chk("fill_rd", 2'(a), exp_q.pop_front());

        // 6. Reset mid-debounce with the button still held
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        p0 = n_pulse;
        wr_addr = 2'd0;
        wr_data = 8'h77;
        rd_addr = 2'd0;
        wr_btn  = 1'b1;
        step(3);
        check("mid_in_deb", 32'(dbg_state), 32'(DEB_PRESS));
        rst = 1'b1;
        step(1);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        first_k = 0;
        npk = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (wr_pulse) begin
                npk++;
                if (first_k == 0) first_k = k;
            end
        end
        check("mid_npulse", 32'(npk), 32'd1);
        check("mid_latency", 32'(first_k), 32'(DC + 3));
        check("mid_valid", 32'(valid), 32'b0001);
        check("mid_rd0", 32'(rd_data), 32'h77);
`ifdef MEM_STORE_WRCOUNT_EN
        check("mid_wr_count", 32'(wr_count), 32'd1);
`endif
        wr_btn = 1'b0;
        step(12);
        check("mid_busy_rel", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
